// File: rtl/pe_mac_drain.sv
// Systolic-array processing element: forwards activations/weights, accumulates
// act*w over a programmed number of steps, then places the result on a drain chain.
module pe_mac_drain #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 36,
    parameter int CNT_W  = 8,
    parameter int SAT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] act_left,
    input  logic              act_valid_in,
    input  logic [DATA_W-1:0] w_top,
    input  logic              w_valid_in,
    output logic [DATA_W-1:0] act_right,
    output logic              act_valid_out,
    output logic [DATA_W-1:0] w_bottom,
    output logic              w_valid_out,
    input  logic              drain,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_in_valid,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_out_valid,
    output logic              busy,
    output logic              done,
    output logic              ovf
);
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               sm_q, sm_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   psum_q, psum_d;
    logic               psumv_q, psumv_d;
    logic [DATA_W-1:0]  act_q, w_q;
    logic               actv_q, wv_q;
    logic               busy_q, done_q;
    logic               step, last, take_start;
    logic [ACC_W:0]     sum_r;

    // Full-width product, sign- or zero-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b,
                                                        input logic sm);
        logic signed [PW-1:0] sp;
        logic [PW-1:0]        up;
        sp = PW'($signed(a)) * PW'($signed(b));
        up = PW'(a) * PW'(b);
        if (sm)
            return ACC_W'(sp);
        return $signed(ACC_W'(up));
    endfunction

    function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W-1:0] r, input logic o,
                                                  input logic neg, input logic sm);
        if (SAT == 0 || !o)
            return r;
        if (!sm)
            return '1;
        return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    // Returns {overflow, next accumulator}; overflow is carry-out (unsigned) or signed overflow.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic signed [ACC_W-1:0] p,
                                               input logic sm);
        logic [ACC_W:0] sum;
        logic           o;
        sum = {1'b0, acc} + {1'b0, p};
        if (sm)
            o = (acc[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        else
            o = sum[ACC_W];
        return {o, saturate(sum[ACC_W-1:0], o, acc[ACC_W-1], sm)};
    endfunction

    assign step       = (state_q == S_ACC) && act_valid_in && w_valid_in;
    assign last       = (cnt_q == len_q - CNT_W'(1));
    assign take_start = start && ((state_q == S_IDLE) || ((state_q == S_DONE) && drain));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else if (en)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (len == '0) ? S_DONE : S_ACC;
            S_ACC:  if (step && last) state_d = S_DONE;
            S_DONE: if (drain) state_d = !start ? S_IDLE : ((len == '0) ? S_DONE : S_ACC);
            default: state_d = S_IDLE;
        endcase
    end

    // Draining in DONE and restarting in the same cycle both use the old accumulator.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sm_d    = sm_q;
        ovf_d   = ovf_q;
        psum_d  = psum_in;
        psumv_d = psum_in_valid;
        sum_r   = acc_add(acc_q, mul_ext(act_left, w_top, sm_q), sm_q);
        if (state_q == S_DONE) begin
            psum_d  = drain ? acc_q : psum_q;
            psumv_d = drain;
        end
        if (take_start) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            len_d = len;
            sm_d  = signed_mode;
        end else if (step) begin
            acc_d = sum_r[ACC_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sum_r[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sm_q    <= 1'b0;
            ovf_q   <= 1'b0;
            psum_q  <= '0;
            psumv_q <= 1'b0;
            act_q   <= '0;
            actv_q  <= 1'b0;
            w_q     <= '0;
            wv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sm_q    <= sm_d;
            ovf_q   <= ovf_d;
            psum_q  <= psum_d;
            psumv_q <= psumv_d;
            act_q   <= act_left;
            actv_q  <= act_valid_in;
            w_q     <= w_top;
            wv_q    <= w_valid_in;
            busy_q  <= (state_d == S_ACC);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign act_right      = act_q;
    assign act_valid_out  = actv_q;
    assign w_bottom       = w_q;
    assign w_valid_out    = wv_q;
    assign psum_out       = psum_q;
    assign psum_out_valid = psumv_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign ovf            = ovf_q;
endmodule

// File: tb/tb_pe_mac_drain.sv
// Bench for pe_mac_drain: three instances (36-bit wrap, 32-bit saturate, 32-bit wrap)
// share one stimulus stream and are compared every cycle against an arithmetic model.
`timescale 1ns/1ps
module tb_pe_mac_drain;
    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk, rst_n, en, start, signed_mode, drain;
    logic [CW-1:0] len;
    logic [DW-1:0] act_left, w_top;
    logic          act_valid_in, w_valid_in, psum_in_valid;
    logic [35:0]   psum_in;
    logic [DW-1:0] ar [3];
    logic [DW-1:0] wb [3];
    logic          arv [3];
    logic          wbv [3];
    logic          pov [3];
    logic          bsy [3];
    logic          dn  [3];
    logic          ov  [3];
    logic [35:0]   po0;
    logic [31:0]   po1, po2;

    int n_tests, n_fail;

    typedef struct packed {
        int     ph;   // 0 idle, 1 accumulating, 2 holding result
        longint acc;
        int     cnt;
        int     len;
        bit     sm;
        bit     ovf;
        longint ps;
        bit     psv;
    } mdl_t;

    mdl_t          m [3];
    logic [DW-1:0] e_act, e_w;
    bit            e_actv, e_wv;

    pe_mac_drain #(.DATA_W(DW), .ACC_W(36), .CNT_W(CW), .SAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .len(len), .signed_mode(signed_mode),
        .act_left(act_left), .act_valid_in(act_valid_in), .w_top(w_top), .w_valid_in(w_valid_in),
        .act_right(ar[0]), .act_valid_out(arv[0]), .w_bottom(wb[0]), .w_valid_out(wbv[0]),
        .drain(drain), .psum_in(psum_in), .psum_in_valid(psum_in_valid),
        .psum_out(po0), .psum_out_valid(pov[0]), .busy(bsy[0]), .done(dn[0]), .ovf(ov[0]));

    pe_mac_drain #(.DATA_W(DW), .ACC_W(32), .CNT_W(CW), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .len(len), .signed_mode(signed_mode),
        .act_left(act_left), .act_valid_in(act_valid_in), .w_top(w_top), .w_valid_in(w_valid_in),
        .act_right(ar[1]), .act_valid_out(arv[1]), .w_bottom(wb[1]), .w_valid_out(wbv[1]),
        .drain(drain), .psum_in(psum_in[31:0]), .psum_in_valid(psum_in_valid),
        .psum_out(po1), .psum_out_valid(pov[1]), .busy(bsy[1]), .done(dn[1]), .ovf(ov[1]));

    pe_mac_drain #(.DATA_W(DW), .ACC_W(32), .CNT_W(CW), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .len(len), .signed_mode(signed_mode),
        .act_left(act_left), .act_valid_in(act_valid_in), .w_top(w_top), .w_valid_in(w_valid_in),
        .act_right(ar[2]), .act_valid_out(arv[2]), .w_bottom(wb[2]), .w_valid_out(wbv[2]),
        .drain(drain), .psum_in(psum_in[31:0]), .psum_in_valid(psum_in_valid),
        .psum_out(po2), .psum_out_valid(pov[2]), .busy(bsy[2]), .done(dn[2]), .ovf(ov[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int aw_of(input int i);
        return (i == 0) ? 36 : 32;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 1);
    endfunction

    function automatic longint po_of(input int i);
        if (i == 0) return longint'(po0);
        if (i == 1) return longint'(po1);
        return longint'(po2);
    endfunction

    // Interpret a w-bit pattern as a two's-complement number.
    function automatic longint sx(input longint v, input int w);
        if (v >= (longint'(1) << (w - 1)))
            return v - (longint'(1) << w);
        return v;
    endfunction

    function automatic mdl_t mdl_begin(input mdl_t s);
        mdl_t n;
        n     = s;
        n.acc = 0;
        n.cnt = 0;
        n.ovf = 1'b0;
        n.len = int'(len);
        n.sm  = signed_mode;
        n.ph  = (len == '0) ? 2 : 1;
        return n;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input int w, input bit sat);
        mdl_t   n;
        longint p, v, lo, hi, msk;
        n   = s;
        msk = (longint'(1) << w) - 1;
        if (s.ph == 2) begin
            n.psv = drain;
            if (drain) n.ps = s.acc;
        end else begin
            n.psv = psum_in_valid;
            n.ps  = longint'(psum_in) & msk;
        end
        case (s.ph)
            0: if (start) n = mdl_begin(n);
            1: if (act_valid_in && w_valid_in) begin
                if (s.sm) begin
                    p  = longint'($signed(act_left)) * longint'($signed(w_top));
                    lo = -(longint'(1) << (w - 1));
                    hi = (longint'(1) << (w - 1)) - 1;
                    v  = sx(s.acc, w) + p;
                end else begin
                    p  = longint'(act_left) * longint'(w_top);
                    lo = 0;
                    hi = msk;
                    v  = s.acc + p;
                end
                if (v > hi || v < lo) begin
                    n.ovf = 1'b1;
                    if (sat) v = (v > hi) ? hi : lo;
                end
                n.acc = v & msk;
                n.cnt = s.cnt + 1;
                if (n.cnt == s.len) n.ph = 2;
            end
            default: if (drain) begin
                n.ph = 0;
                if (start) n = mdl_begin(n);
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m[i] = '0;
            e_act  = '0;
            e_w    = '0;
            e_actv = 1'b0;
            e_wv   = 1'b0;
        end else if (en) begin
            for (int i = 0; i < 3; i++) m[i] = mdl_step(m[i], aw_of(i), sat_of(i));
            e_act  = act_left;
            e_w    = w_top;
            e_actv = act_valid_in;
            e_wv   = w_valid_in;
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string nm, input longint got, input longint mdl, input longint exp);
        chk({nm, "_dut"}, got, exp);
        chk({nm, "_model"}, mdl, exp);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy[%0d]", i), longint'(bsy[i]), longint'(m[i].ph == 1));
            chk($sformatf("done[%0d]", i), longint'(dn[i]), longint'(m[i].ph == 2));
            chk($sformatf("ovf[%0d]", i), longint'(ov[i]), longint'(m[i].ovf));
            chk($sformatf("psum_out_valid[%0d]", i), longint'(pov[i]), longint'(m[i].psv));
            if (m[i].psv)
                chk($sformatf("psum_out[%0d]", i), po_of(i), m[i].ps);
            chk($sformatf("act_right[%0d]", i), longint'(ar[i]), longint'(e_act));
            chk($sformatf("act_valid_out[%0d]", i), longint'(arv[i]), longint'(e_actv));
            chk($sformatf("w_bottom[%0d]", i), longint'(wb[i]), longint'(e_w));
            chk($sformatf("w_valid_out[%0d]", i), longint'(wbv[i]), longint'(e_wv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mac(input logic [DW-1:0] a, input logic [DW-1:0] b);
        act_left     = a;
        w_top        = b;
        act_valid_in = 1'b1;
        w_valid_in   = 1'b1;
        tick();
        act_valid_in = 1'b0;
        w_valid_in   = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!dn[0] && k < 40) begin
            tick();
            k++;
        end
        chk(nm, longint'(dn[0]), 64'd1);
    endtask

    task automatic go(input logic [CW-1:0] l, input logic sm);
        start       = 1'b1;
        len         = l;
        signed_mode = sm;
        tick();
        start = 1'b0;
    endtask

    task automatic do_drain();
        drain = 1'b1;
        tick();
        drain = 1'b0;
    endtask

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b1; en = 1'b1; start = 1'b0; len = '0; signed_mode = 1'b0; drain = 1'b0;
        act_left = '0; w_top = '0; act_valid_in = 1'b0; w_valid_in = 1'b0;
        psum_in = '0; psum_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        lit("rst_busy", longint'(bsy[0]), longint'(m[0].ph == 1), 64'd0);
        lit("rst_psum", longint'(po0), m[0].ps, 64'd0);
        chk("rst_psv", longint'(pov[0]), 64'd0);

        // Start issued together with reset release: taken on the first active edge.
        rst_n = 1'b1;
        go(8'd3, 1'b0);
        chk("busy_first_start", longint'(bsy[0]), 64'd1);
        mac(16'h0100, 16'h0200);
        mac(16'h0300, 16'h0100);
        mac(16'h0010, 16'h0010);
        wait_done("done_unsigned");
        do_drain();
        // Raw products 0x20000 + 0x30000 + 0x100
        lit("drain_unsigned", longint'(po0), m[0].ps, 64'h5_0100);
        chk("drain_unsigned_v", longint'(pov[0]), 64'd1);
        tick();
        chk("drain_one_cycle", longint'(pov[0]), 64'd0);

        go(8'd2, 1'b1);
        mac(16'hFF00, 16'h0100);
        mac(16'hFF00, 16'h0100);
        wait_done("done_signed");
        do_drain();
        lit("drain_signed36", longint'(po0), m[0].ps, 64'hF_FFFE_0000);
        lit("drain_signed32", longint'(po1), m[1].ps, 64'hFFFE_0000);

        // Gaps in act_valid_in plus one clock-enable hold.
        go(8'd4, 1'b0);
        for (int k = 0; k < 9; k++) begin
            act_left     = DW'(k + 1);
            w_top        = DW'(k + 2);
            act_valid_in = (k % 2 == 0);
            w_valid_in   = 1'b1;
            en           = (k != 4);
            tick();
            en = 1'b1;
            if (k == 4) begin
                lit("freeze_act", longint'(ar[0]), longint'(e_act), 64'd4);
                chk("freeze_actv", longint'(arv[0]), 64'd0);
            end
            if (k < 8) chk("busy_gaps", longint'(bsy[0]), 64'd1);
        end
        act_valid_in = 1'b0;
        w_valid_in   = 1'b0;
        wait_done("done_gaps");
        do_drain();
        lit("drain_gaps", longint'(po0), m[0].ps, 64'hA0);

        go(8'd3, 1'b0);
        repeat (3) mac(16'hFFFF, 16'hFFFF);
        wait_done("done_ovf");
        lit("ovf36", longint'(ov[0]), longint'(m[0].ovf), 64'd0);
        lit("ovf_sat", longint'(ov[1]), longint'(m[1].ovf), 64'd1);
        lit("ovf_wrap", longint'(ov[2]), longint'(m[2].ovf), 64'd1);
        do_drain();
        lit("acc36", longint'(po0), m[0].ps, 64'h2_FFFA_0003);
        lit("acc_sat", longint'(po1), m[1].ps, 64'hFFFF_FFFF);
        lit("acc_wrap", longint'(po2), m[2].ps, 64'hFFFA_0003);

        psum_in = 36'h123; psum_in_valid = 1'b1;
        tick();
        psum_in_valid = 1'b0;
        lit("pass_idle", longint'(po0), m[0].ps, 64'h123);
        chk("pass_idle_v", longint'(pov[0]), 64'd1);
        go(8'd1, 1'b0);
        mac(16'h0002, 16'h0003);
        psum_in = 36'h456; psum_in_valid = 1'b1;
        tick();
        psum_in_valid = 1'b0;
        chk("drop_in_done", longint'(pov[0]), 64'd0);
        start = 1'b1; len = 8'd2; drain = 1'b1;
        tick();
        start = 1'b0; drain = 1'b0;
        lit("drain_start", longint'(po0), m[0].ps, 64'd6);
        chk("drain_start_v", longint'(pov[0]), 64'd1);
        chk("drain_start_busy", longint'(bsy[0]), 64'd1);
        mac(16'h0001, 16'h0001);
        mac(16'h0001, 16'h0001);
        wait_done("done_restart");
        do_drain();
        lit("drain_restart", longint'(po0), m[0].ps, 64'd2);

        go(8'd3, 1'b0);
        mac(16'h0005, 16'h0005);
        act_left = 16'h0007; w_top = 16'h0007; act_valid_in = 1'b1; w_valid_in = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", longint'(bsy[0]), 64'd0);
        chk("rst_mid_done", longint'(dn[0]), 64'd0);
        chk("rst_mid_act", longint'(ar[0]), 64'd0);
        chk("rst_mid_actv", longint'(arv[0]), 64'd0);
        chk("rst_mid_psum", longint'(po0), 64'd0);
        chk("rst_mid_psv", longint'(pov[0]), 64'd0);
        tick();
        act_valid_in = 1'b0; w_valid_in = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_done", longint'(dn[0]), 64'd0);
            chk("post_rst_psv", longint'(pov[0]), 64'd0);
        end

        for (int c = 0; c < 4000; c++) begin
            en            = ($urandom_range(0, 9) != 0);
            start         = ($urandom_range(0, 3) == 0);
            len           = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 24)) : CW'($urandom_range(0, 4));
            signed_mode   = 1'($urandom_range(0, 1));
            act_left      = pick();
            w_top         = pick();
            act_valid_in  = ($urandom_range(0, 3) != 0);
            w_valid_in    = ($urandom_range(0, 3) != 0);
            drain         = ($urandom_range(0, 2) == 0);
            psum_in       = {4'($urandom), $urandom};
            psum_in_valid = 1'($urandom_range(0, 1));
            rst_n         = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1; en = 1'b1; start = 1'b0; drain = 1'b0;
        act_valid_in = 1'b0; w_valid_in = 1'b0; psum_in_valid = 1'b0;
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
